// File: rtl/commit_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : commit_sequencer                                           |
// | Description : In-order retire sequencer. Commits up to NR_COMMIT_PORTS   |
// |               entries per cycle, drains the store path for fences and    |
// |               waits for the atomic unit on AMOs.                         |
// |               Optional build macro COMMIT_PERF_CNT_EN enables the        |
// |               retire_cnt_o / instret_o performance counters.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module commit_sequencer #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DRAIN_TIMEOUT   = 255,
  parameter int unsigned XLEN            = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NR_COMMIT_PORTS-1:0]            instr_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0][2:0]       instr_cls_i,
  input  logic [NR_COMMIT_PORTS-1:0]            instr_ex_i,
  input  logic [NR_COMMIT_PORTS-1:0][4:0]       instr_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  instr_result_i,
  input  logic                                  halt_i,
  input  logic                                  single_step_i,
  input  logic                                  lsu_ready_i,
  input  logic                                  no_st_pending_i,
  input  logic                                  amo_ack_i,
  input  logic [XLEN-1:0]                       amo_result_i,
  output logic [NR_COMMIT_PORTS-1:0]            commit_ack_o,
  output logic [NR_COMMIT_PORTS-1:0]            we_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]       waddr_o,
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  wdata_o,
  output logic                                  commit_lsu_o,
  output logic                                  commit_csr_o,
  output logic                                  amo_valid_o,
  output logic                                  fence_o,
  output logic                                  fence_i_o,
  output logic                                  sfence_vma_o,
  output logic                                  flush_o,
  output logic                                  exception_o,
  output logic                                  drain_timeout_o,
  output logic [2:0]                            retire_cnt_o,
  output logic [63:0]                           instret_o
);

  localparam int         N          = int'(NR_COMMIT_PORTS);
  localparam logic [2:0] CLS_SIMPLE = 3'd0;
  localparam logic [2:0] CLS_STORE  = 3'd1;
  localparam logic [2:0] CLS_CSR    = 3'd2;
  localparam logic [2:0] CLS_FENCE  = 3'd3;
  localparam logic [2:0] CLS_FENCEI = 3'd4;
  localparam logic [2:0] CLS_SFENCE = 3'd5;
  localparam logic [2:0] CLS_AMO    = 3'd6;
  localparam logic [15:0] TIMEOUT_C = 16'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_AMO_WAIT = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [15:0]                     drain_cnt_q, drain_cnt_d;

  logic [N-1:0]                    w_ack;
  logic [N-1:0]                    w_we;
  logic                            w_lsu;
  logic                            w_csr;
  logic                            w_amo_valid;
  logic                            w_fence;
  logic                            w_fence_i;
  logic                            w_sfence;
  logic                            w_flush;
  logic                            w_exc;
  logic                            w_amo_wb;
  logic                            w_chain;
  logic                            w_store_seen;
  logic                            w_drain_to;
  logic [N-1:0][XLEN-1:0]          w_wdata;

  // State and drain-counter registers; reset abandons any fence/AMO in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next state plus port-0 retire decision and single-cycle side-band pulses.
  always_comb begin
    state_d     = state_q;
    w_ack       = '0;
    w_csr       = 1'b0;
    w_amo_valid = 1'b0;
    w_fence     = 1'b0;
    w_fence_i   = 1'b0;
    w_sfence    = 1'b0;
    w_flush     = 1'b0;
    w_exc       = 1'b0;
    w_amo_wb    = 1'b0;
    w_chain     = 1'b0;
    w_store_seen = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid_i[0] && !halt_i) begin
          if (instr_ex_i[0]) begin
            w_exc = 1'b1;
          end else begin
            case (instr_cls_i[0])
              CLS_SIMPLE: w_ack[0] = 1'b1;
              CLS_STORE:  w_ack[0] = lsu_ready_i;
              CLS_CSR: begin
                w_ack[0] = 1'b1;
                w_csr    = 1'b1;
              end
              CLS_FENCE, CLS_FENCEI, CLS_SFENCE: state_d = ST_DRAIN;
              CLS_AMO:    state_d = ST_AMO_WAIT;
              default:    ;
            endcase
          end
        end
      end
      ST_DRAIN: begin
        // Halt wins over drain completion: the fence is re-issued later.
        if (halt_i) begin
          state_d = ST_IDLE;
        end else if (no_st_pending_i) begin
          w_ack[0]  = 1'b1;
          w_fence   = (instr_cls_i[0] == CLS_FENCE);
          w_fence_i = (instr_cls_i[0] == CLS_FENCEI);
          w_sfence  = (instr_cls_i[0] == CLS_SFENCE);
          state_d   = ST_IDLE;
        end
      end
      ST_AMO_WAIT: begin
        w_amo_valid = 1'b1;
        if (amo_ack_i) begin
          w_ack[0] = 1'b1;
          w_flush  = 1'b1;
          w_amo_wb = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Upper ports retire strictly in order behind port 0, only simple ops or
    // a single store per cycle, and never while single-stepping.
    w_chain      = w_ack[0] && (state_q == ST_IDLE) && !single_step_i;
    w_store_seen = w_ack[0] && (instr_cls_i[0] == CLS_STORE);
    for (int i = 1; i < N; i++) begin
      if (w_chain && instr_valid_i[i] && !instr_ex_i[i] &&
          ((instr_cls_i[i] == CLS_SIMPLE) ||
           ((instr_cls_i[i] == CLS_STORE) && lsu_ready_i && !w_store_seen))) begin
        w_ack[i] = 1'b1;
        if (instr_cls_i[i] == CLS_STORE) w_store_seen = 1'b1;
      end else begin
        w_chain = 1'b0;
      end
    end
  end

  // Write enables and the single LSU commit strobe follow the acks.
  always_comb begin
    w_we  = '0;
    w_lsu = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_we[i] = w_ack[i] && (instr_cls_i[i] != CLS_STORE);
      if (w_ack[i] && (instr_cls_i[i] == CLS_STORE)) w_lsu = 1'b1;
    end
  end

  // Drain counter restarts at zero on every DRAIN entry and saturates.
  always_comb begin
    drain_cnt_d = '0;
    if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
      drain_cnt_d = (drain_cnt_q == 16'hFFFF) ? drain_cnt_q : drain_cnt_q + 16'd1;
    end
  end

  assign w_drain_to = (state_q == ST_DRAIN) && (drain_cnt_q >= TIMEOUT_C);

  // Port 0 write data is replaced by the AMO load value when the AMO retires.
  always_comb begin
    w_wdata = instr_result_i;
    if (w_amo_wb) w_wdata[0] = amo_result_i;
  end

  // While reset is held every combinational output reads as zero.
  assign commit_ack_o    = rst_ni ? w_ack        : '0;
  assign we_o            = rst_ni ? w_we         : '0;
  assign waddr_o         = rst_ni ? instr_rd_i   : '0;
  assign wdata_o         = rst_ni ? w_wdata      : '0;
  assign commit_lsu_o    = rst_ni & w_lsu;
  assign commit_csr_o    = rst_ni & w_csr;
  assign amo_valid_o     = rst_ni & w_amo_valid;
  assign fence_o         = rst_ni & w_fence;
  assign fence_i_o       = rst_ni & w_fence_i;
  assign sfence_vma_o    = rst_ni & w_sfence;
  assign flush_o         = rst_ni & w_flush;
  assign exception_o     = rst_ni & w_exc;
  assign drain_timeout_o = rst_ni & w_drain_to;

`ifdef COMMIT_PERF_CNT_EN
  logic [2:0]  w_retire_cnt;
  logic [63:0] instret_q, instret_d;

  // Population count of this cycle's acks.
  always_comb begin
    w_retire_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_retire_cnt = w_retire_cnt + 3'(w_ack[i]);
    end
  end

  assign instret_d = instret_q + 64'(w_retire_cnt);

  // Retired-instruction counter, wraps naturally at 2^64.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) instret_q <= '0;
    else         instret_q <= instret_d;
  end

  assign retire_cnt_o = rst_ni ? w_retire_cnt : '0;
  assign instret_o    = instret_q;
`else
  assign retire_cnt_o = '0;
  assign instret_o    = '0;
`endif

endmodule
`default_nettype wire

// File: doc/commit_sequencer.md
COMMIT_SEQUENCER -- requirements
Module: commit_sequencer

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2, number of retire ports; legal range 1..4.
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 255, DRAIN cycles before timeout flag; legal range 1..65535.
REQ-003 SHALL have ports, one clock; reset is asynchronous and active-low:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- instr_valid_i  in  N  per-port entry valid
- instr_cls_i  in  N x 3  class: 0 SIMPLE, 1 STORE, 2 CSR, 3 FENCE, 4 FENCE_I, 5 SFENCE, 6 AMO
- instr_ex_i  in  N  entry carries exception
- instr_rd_i  in  N x 5  destination register
- instr_result_i  in  N x XLEN  result
- halt_i, single_step_i, lsu_ready_i, no_st_pending_i  in  1 each  control
- amo_ack_i  in  1  AMO done
- amo_result_i  in  XLEN  AMO load value
- commit_ack_o, we_o  out  N each  retire / regfile write enable
- waddr_o  out  N x 5;  wdata_o  out  N x XLEN
- commit_lsu_o, commit_csr_o, amo_valid_o, fence_o, fence_i_o, sfence_vma_o, flush_o  out  1 each
- exception_o  out  1  port-0 exception taken
- drain_timeout_o  out  1  DRAIN exceeded DRAIN_TIMEOUT
- retire_cnt_o  out  3  acks this cycle
- instret_o  out  64  retired-instruction count

Function
REQ-004 SHALL implement FSM {IDLE, DRAIN, AMO_WAIT}; all outputs other than state-derived ones are combinational from inputs and state.
REQ-005 IDLE, port 0 valid, !ex, !halt: SIMPLE -> ack+we same cycle; STORE -> ack+commit_lsu_o iff lsu_ready_i, we=0; CSR -> ack, commit_csr_o, we.
REQ-006 IDLE, port 0 cls FENCE/FENCE_I/SFENCE: no ack; next state DRAIN.
REQ-007 DRAIN: when no_st_pending_i=1 -> ack port 0, pulse matching fence_o/fence_i_o/sfence_vma_o one cycle, next IDLE; halt_i in DRAIN -> IDLE with no ack/pulse.
REQ-008 DRAIN cycle counter (16 bit) SHALL start at 0 on entry, saturate; drain_timeout_o=1 while count >= DRAIN_TIMEOUT; cleared on exit.
REQ-009 IDLE, port 0 AMO: next AMO_WAIT; AMO_WAIT drives amo_valid_o=1; on amo_ack_i: ack, we, wdata_o[0]=amo_result_i, flush_o=1, next IDLE; halt_i ignored in AMO_WAIT.
REQ-010 Port i>0 SHALL ack only when state=IDLE, ports 0..i-1 all ack, !single_step_i, !halt_i, valid, !ex, cls SIMPLE, or cls STORE with lsu_ready_i and no lower port STORE this cycle.
REQ-011 At most one commit_lsu_o per cycle; we_o[i]=ack[i] except STORE (we=0).
REQ-012 Port 0 valid with instr_ex_i, state IDLE, !halt_i: exception_o=1, no acks any port.
REQ-013 waddr_o[i]=instr_rd_i[i]; wdata_o[i]=instr_result_i[i] except REQ-009.
REQ-014 retire_cnt_o SHALL equal popcount(commit_ack_o).
REQ-015 instret_o SHALL add retire_cnt_o on the next clock edge, wrapping modulo 2^64.
REQ-016 Invalid port 0 entry in IDLE: no acks, no state change.

Reset
REQ-017 rst_ni low SHALL immediately force state IDLE, drain counter 0, instret_o 0; all combinational outputs then 0.
REQ-018 Reset mid-DRAIN or mid-AMO_WAIT SHALL abandon the operation without ack or pulse.

Configuration
REQ-019 Macro COMMIT_PERF_CNT_EN defined: REQ-014/015 implemented. Undefined: retire_cnt_o and instret_o tied 0, no counter flops.

Verification
REQ-020 N=2, both SIMPLE valid, rd 3/4 -> ack=11, we=11, retire_cnt=2, instret +2 next cycle.
REQ-021 Port 0 FENCE, no_st_pending_i low 3 cycles then high -> ack and fence_o exactly one cycle in 5th cycle; IDLE after.
REQ-022 DRAIN_TIMEOUT=4, no_st_pending_i held low -> drain_timeout_o high from 5th DRAIN cycle; halt_i -> IDLE, flag low, no ack.
REQ-023 Port 0 AMO, amo_ack_i after 6 cycles with result 0xDEAD -> amo_valid_o 6 cycles, ack+we+flush_o one cycle, wdata_o[0]=0xDEAD.
REQ-024 N=4, ports STORE,STORE,SIMPLE,SIMPLE, lsu_ready_i=1 -> ack=0001, commit_lsu_o=1; port 0 instr_ex_i=1 -> exception_o=1, ack=0000.
REQ-025 single_step_i=1, two SIMPLE -> ack=01; reset asserted mid-AMO_WAIT -> instret_o 0, state IDLE, no flush_o.
